// File: rtl/branch_sequencer.sv
// Branch-class control sequencer for B, BL, BR, CBZ/CBNZ and B.cond: IDLE -> [LINK|TEST] -> EXEC.
// Optional BRANCH_STATS_EN adds exec_count / taken_count statistics outputs.
module branch_sequencer #(
  parameter int          DATA_WIDTH  = 64,
  parameter logic [4:0]  LINK_REG    = 5'd30,
  parameter logic [4:0]  FSEL_PASS_A = 5'b00100,
  parameter logic [1:0]  DSEL_PC     = 2'b10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           instruction,
  input  logic [3:0]            flags,
  input  logic                  alu_zero,
  output logic [28:0]           controlWord,
  output logic [DATA_WIDTH-1:0] K,
  output logic                  busy,
  output logic                  done,
  output logic                  taken,
  output logic                  illegal
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]           taken_count,
  output logic [31:0]           exec_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LINK, S_TEST, S_EXEC} state_t;
  typedef enum logic [2:0] {C_B, C_BL, C_CB, C_BCOND, C_BR, C_ILL} cls_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        zero_q, zero_d;

  function automatic cls_t decode(input logic [31:0] w);
    cls_t c;
    if (w[31:26] == 6'b000101)                         c = C_B;
    else if (w[31:26] == 6'b100101)                    c = C_BL;
    else if (w[30:25] == 6'b011010)                    c = C_CB;
    else if (w[31:24] == 8'b01010100)                  c = C_BCOND;
    else if (w[31:10] == 22'b1101011000011111000000)   c = C_BR;
    else                                               c = C_ILL;
    return c;
  endfunction

  // Condition field: bits [3:1] pick the test, bit 0 inverts it except for 1111 (always).
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, r;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'b000:  r = z;
      3'b001:  r = cf;
      3'b010:  r = n;
      3'b011:  r = v;
      3'b100:  r = cf & ~z;
      3'b101:  r = (n == v);
      3'b110:  r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && (c != 4'hF)) r = ~r;
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= 32'd0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          instr_d = instruction;
          case (decode(instruction))
            C_BL:    state_d = S_LINK;
            C_CB:    state_d = S_TEST;
            default: state_d = S_EXEC;
          endcase
        end
      end
      S_LINK: state_d = S_EXEC;
      S_TEST: begin
        zero_d  = alu_zero;
        state_d = S_EXEC;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [1:0] psel_c, dsel_c;
  logic [4:0] da_c, sa_c, fsel_c;
  logic       regw_c, pcsel_c, taken_c;
  logic [DATA_WIDTH-1:0] k_c;
  cls_t       cls_c;

  always_comb begin
    psel_c  = 2'b00;
    dsel_c  = 2'b00;
    da_c    = 5'd0;
    sa_c    = 5'd0;
    fsel_c  = 5'd0;
    regw_c  = 1'b0;
    pcsel_c = 1'b0;
    taken_c = 1'b0;
    k_c     = '0;
    busy    = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    cls_c   = decode(instr_q);
    case (state_q)
      S_LINK: begin
        busy   = 1'b1;
        da_c   = LINK_REG;
        regw_c = 1'b1;
        dsel_c = DSEL_PC;
      end
      S_TEST: begin
        busy   = 1'b1;
        sa_c   = instr_q[4:0];
        fsel_c = FSEL_PASS_A;
      end
      S_EXEC: begin
        busy = 1'b1;
        done = 1'b1;
        case (cls_c)
          C_B, C_BL: begin
            taken_c = 1'b1;
            k_c     = {{(DATA_WIDTH-26){instr_q[25]}}, instr_q[25:0]};
          end
          C_CB: begin
            taken_c = instr_q[24] ? ~zero_q : zero_q;
            k_c     = {{(DATA_WIDTH-19){instr_q[23]}}, instr_q[23:5]};
          end
          C_BCOND: begin
            taken_c = cond_pass(instr_q[3:0], flags);
            k_c     = {{(DATA_WIDTH-19){instr_q[23]}}, instr_q[23:5]};
          end
          C_BR: begin
            taken_c = 1'b1;
            sa_c    = instr_q[9:5];
          end
          default: illegal = 1'b1;
        endcase
        // PC-relative redirect whenever a non-register branch is taken; otherwise fall through.
        if (cls_c == C_BR)  psel_c = 2'b10;
        else if (taken_c)   psel_c = 2'b11;
        else                psel_c = 2'b01;
        pcsel_c = (psel_c == 2'b11);
      end
      default: ;
    endcase
    taken       = taken_c;
    K           = k_c;
    controlWord = {psel_c, da_c, sa_c, 5'd0, fsel_c, regw_c, 1'b0, dsel_c, 1'b0, pcsel_c, 1'b0};
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt_q, exec_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      taken_cnt_q <= 32'd0;
      exec_cnt_q  <= 32'd0;
    end else if (done) begin
      exec_cnt_q <= exec_cnt_q + 32'd1;
      if (taken_c) taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign taken_count = taken_cnt_q;
  assign exec_count  = exec_cnt_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed cases plus random branches against a cycle-list reference model.
module tb_branch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instruction;
  logic [3:0]  flags;
  logic        alu_zero;
  logic [28:0] controlWord;
  logic [63:0] K;
  logic        busy, done, taken, illegal;
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_count, exec_count;
  int          m_exec, m_taken;
`endif

  int total = 0;
  int bad   = 0;

  // Each entry: {controlWord[28:0], K[63:0], busy, done, taken, illegal}
  logic [96:0] exp_q[$];

  branch_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .instruction(instruction),
    .flags(flags), .alu_zero(alu_zero), .controlWord(controlWord), .K(K),
    .busy(busy), .done(done), .taken(taken), .illegal(illegal)
`ifdef BRANCH_STATS_EN
    , .taken_count(taken_count), .exec_count(exec_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
    if (v[bits-1]) return v - (64'd1 << bits);
    return v;
  endfunction

  function automatic logic [28:0] cw(input logic [1:0] psel, input logic [4:0] da, input logic [4:0] sa,
                                     input logic [4:0] fsel, input logic regw, input logic [1:0] dsel,
                                     input logic pcsel);
    return {psel, da, sa, 5'd0, fsel, regw, 1'b0, dsel, 1'b0, pcsel, 1'b0};
  endfunction

  function automatic logic arm_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return (n ^ v) == 1'b0;
      4'd11: return (n ^ v) == 1'b1;
      4'd12: return !z && (n ^ v) == 1'b0;
      4'd13: return z || (n ^ v) == 1'b1;
      default: return 1'b1;
    endcase
  endfunction

  // Returns class: 0 B, 1 BL, 2 CB, 3 B.cond, 4 BR, 5 illegal; fills exp_q with the cycles after start.
  function automatic int build(input logic [31:0] ins, input logic [3:0] fl, input logic az);
    int cls;
    logic tk, ill;
    logic [1:0] psel;
    logic [4:0] sa;
    logic [63:0] kv;
    if (ins[31:26] == 6'b000101)                       cls = 0;
    else if (ins[31:26] == 6'b100101)                  cls = 1;
    else if (ins[30:25] == 6'b011010)                  cls = 2;
    else if (ins[31:24] == 8'h54)                      cls = 3;
    else if (ins[31:10] == 22'b1101011000011111000000) cls = 4;
    else                                               cls = 5;
    if (cls == 1) exp_q.push_back({cw(2'b00, 5'd30, 5'd0, 5'd0, 1'b1, 2'b10, 1'b0), 64'd0, 4'b1000});
    if (cls == 2) exp_q.push_back({cw(2'b00, 5'd0, ins[4:0], 5'b00100, 1'b0, 2'b00, 1'b0), 64'd0, 4'b1000});
    tk = 1'b0; ill = 1'b0; sa = 5'd0; kv = 64'd0;
    case (cls)
      0, 1: begin tk = 1'b1; kv = sext({38'd0, ins[25:0]}, 26); end
      2:    begin tk = ins[24] ? !az : az; kv = sext({45'd0, ins[23:5]}, 19); end
      3:    begin tk = arm_cond(ins[3:0], fl); kv = sext({45'd0, ins[23:5]}, 19); end
      4:    begin tk = 1'b1; sa = ins[9:5]; end
      default: ill = 1'b1;
    endcase
    if (cls == 4) psel = 2'b10;
    else          psel = tk ? 2'b11 : 2'b01;
    exp_q.push_back({cw(psel, 5'd0, sa, 5'd0, 1'b0, 2'b00, psel == 2'b11), kv, 1'b1, 1'b1, tk, ill});
    exp_q.push_back({29'd0, 64'd0, 4'b0000});
    return cls;
  endfunction

  task automatic check_entry(input string tag, input logic [96:0] e);
    chk({tag, "_cw"}, {35'd0, controlWord}, {35'd0, e[96:68]});
    chk({tag, "_k"}, K, e[67:4]);
    chk({tag, "_st"}, {60'd0, busy, done, taken, illegal}, {60'd0, e[3:0]});
  endtask

  // One full branch from IDLE back to IDLE; poke re-asserts start while the sequence is busy.
  task automatic run(input string tag, input logic [31:0] ins, input logic [3:0] fl, input logic az,
                     input logic poke);
    int cls, n;
    logic [96:0] e;
    cls = build(ins, fl, az);
    n = exp_q.size();
    instruction = ins; flags = fl; alu_zero = !az; start = 1'b1;
    step();
    start = 1'b0;
    instruction = $urandom;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check_entry(tag, e);
`ifdef BRANCH_STATS_EN
      if (e[2]) begin m_exec++; if (e[1]) m_taken++; end
`endif
      if (i == 0 && cls == 2) alu_zero = az;
      if (i == 0 && n == 3 && poke) begin
        start = 1'b1;
        instruction = {6'b000101, 26'h155};
      end
      if (i < n - 1) step();
      start = 1'b0;
      alu_zero = !az;
    end
  endtask

  function automatic logic [31:0] rand_ins();
    case ($urandom_range(0, 5))
      0: return {6'b000101, 26'($urandom)};
      1: return {6'b100101, 26'($urandom)};
      2: return {1'($urandom), 6'b011010, 1'($urandom), 19'($urandom), 5'($urandom)};
      3: return {8'h54, 19'($urandom), 1'b0, 4'($urandom)};
      4: return {22'b1101011000011111000000, 5'($urandom), 5'd0};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; instruction = 32'd0; flags = 4'd0; alu_zero = 1'b0;
`ifdef BRANCH_STATS_EN
    m_exec = 0; m_taken = 0;
`endif
    repeat (3) step();
    reset = 1'b0;
    check_entry("reset", {29'd0, 64'd0, 4'b0000});

    run("b_neg", {6'b000101, 26'h3FFFFFF}, 4'h0, 1'b0, 1'b0);
    run("bl", {6'b100101, 26'h10}, 4'h0, 1'b0, 1'b0);
    run("cbz_z1", {1'b1, 6'b011010, 1'b0, 19'h7, 5'd5}, 4'h0, 1'b1, 1'b0);
    run("cbz_z0", {1'b1, 6'b011010, 1'b0, 19'h7, 5'd5}, 4'h0, 1'b0, 1'b0);
    run("cbnz_z1", {1'b1, 6'b011010, 1'b1, 19'h40000, 5'd5}, 4'h0, 1'b1, 1'b0);
    run("cbnz_z0", {1'b1, 6'b011010, 1'b1, 19'h40000, 5'd5}, 4'h0, 1'b0, 1'b0);
    run("bge_nt", {8'h54, 19'h12, 1'b0, 4'hA}, 4'b1000, 1'b0, 1'b0);
    run("bge_t", {8'h54, 19'h12, 1'b0, 4'hA}, 4'b1001, 1'b0, 1'b0);
    run("b_nv", {8'h54, 19'h7FFFF, 1'b0, 4'hF}, 4'b0000, 1'b0, 1'b0);
    run("br", {22'b1101011000011111000000, 5'd17, 5'd0}, 4'h0, 1'b0, 1'b0);
    run("illegal", 32'h0000_0000, 4'h0, 1'b0, 1'b0);
    run("bl_poke", {6'b100101, 26'h2000000}, 4'h0, 1'b0, 1'b1);
    run("cb_poke", {1'b0, 6'b011010, 1'b0, 19'h3, 5'd9}, 4'h0, 1'b1, 1'b1);

    // start held through the EXEC->IDLE edge is taken only on the following edge
    instruction = {6'b000101, 26'h1}; start = 1'b1;
    step();
    chk("b2b_exec", {60'd0, busy, done, taken, illegal}, 64'hE);
    instruction = {6'b000101, 26'h22};
    step();
    chk("b2b_idle", {35'd0, controlWord}, 64'd0);
    chk("b2b_idle_busy", {63'd0, busy}, 64'd0);
    step();
    start = 1'b0;
    chk("b2b_second_done", {63'd0, done}, 64'd1);
    chk("b2b_second_k", K, 64'h22);
    step();
`ifdef BRANCH_STATS_EN
    m_exec += 2; m_taken += 2;
`endif

    // reset during TEST aborts without a done pulse
    instruction = {1'b1, 6'b011010, 1'b0, 19'h5, 5'd3}; start = 1'b1;
    step();
    start = 1'b0;
    chk("abort_in_test", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_cw", {35'd0, controlWord}, 64'd0);
    chk("abort_st", {60'd0, busy, done, taken, illegal}, 64'd0);
    step();
    chk("abort_no_done", {63'd0, done}, 64'd0);
`ifdef BRANCH_STATS_EN
    m_exec = 0; m_taken = 0;
`endif

    for (int t = 0; t < 60; t++) begin
      run($sformatf("rnd%0d", t), rand_ins(), 4'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) step();
    end

`ifdef BRANCH_STATS_EN
    chk("stat_exec", {32'd0, exec_count}, 64'(m_exec));
    chk("stat_taken", {32'd0, taken_count}, 64'(m_taken));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("stat_clr", {taken_count, exec_count}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
